// File: rtl/apb_wait_slave.sv
// APB3 completer with a word register file, fixed wait states and PSLVERR.
// Word 0 is a read-only ID; writes to it, misaligned or out-of-range accesses error.
module apb_wait_slave #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA5B0_0001
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS_INIT =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic cap_write;
  logic cap_en, wr_en;
  logic rdy_n, err_n;
  logic [DATA_WIDTH-1:0] rdata_n;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // In IDLE the live bus is decoded so a zero-wait access can finish at once.
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic sel_write;
  logic [31:0] idx;
  logic err;
  logic [DATA_WIDTH-1:0] rd;

  always_comb begin
    sel_addr = (state == IDLE) ? paddr : cap_addr;
    sel_write = (state == IDLE) ? pwrite : cap_write;
    idx = 32'(sel_addr[ADDR_WIDTH-1:2]);
    err = (sel_addr[1:0] != 2'b00) ||
          (idx >= 32'(DEPTH)) ||
          (sel_write && (idx == 32'd0));
    rd = (idx == 32'd0) ? ID_VALUE : mem[idx[IW-1:0]];
  end

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rdy_n = 1'b0;
    err_n = 1'b0;
    rdata_n = '0;
    cap_en = 1'b0;
    wr_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (pselx && !penable) begin
          cap_en = 1'b1;
          if (WAIT_STATES == 0) begin
            state_n = DONE;
            rdy_n = 1'b1;
            err_n = err;
            rdata_n = (!sel_write && !err) ? rd : '0;
          end else begin
            state_n = WAIT;
            cnt_n = WS_INIT;
          end
        end
      end
      WAIT: begin
        if (!pselx) begin
          state_n = IDLE;
          cnt_n = '0;
        end else if (penable) begin
          if (cnt == 4'd0) begin
            state_n = DONE;
            rdy_n = 1'b1;
            err_n = err;
            rdata_n = (!sel_write && !err) ? rd : '0;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        wr_en = sel_write && !err;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      cnt <= '0;
      pready <= 1'b0;
      pslverr <= 1'b0;
      prdata <= '0;
      cap_addr <= '0;
      cap_wdata <= '0;
      cap_write <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pready <= rdy_n;
      pslverr <= err_n;
      prdata <= rdata_n;
      if (cap_en) begin
        cap_addr <= paddr;
        cap_wdata <= pwdata;
        cap_write <= pwrite;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx[IW-1:0]] <= cap_wdata;
    end
  end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench: a 2-wait-state and a 0-wait-state completer on a shared bus.
// Inputs change and outputs are sampled on the falling edge.
module tb_apb_wait_slave;

  logic pclk = 1'b0;
  logic presetn;
  logic psel_a, psel_b, penable, pwrite;
  logic [9:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata_a, prdata_b;
  logic pready_a, pready_b, pslverr_a, pslverr_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  apb_wait_slave #(.WAIT_STATES(2)) dut_a (
    .pclk(pclk), .presetn(presetn), .pselx(psel_a),
    .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a),
    .pslverr(pslverr_a)
  );

  apb_wait_slave #(.WAIT_STATES(0)) dut_b (
    .pclk(pclk), .presetn(presetn), .pselx(psel_b),
    .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after completion.
  task automatic xfer(input bit b, input bit w, input logic [9:0] a,
                      input logic [31:0] d, output logic [31:0] rdat,
                      output logic er, output int waits);
    paddr = a;
    pwrite = w;
    pwdata = d;
    penable = 1'b0;
    if (b) psel_b = 1'b1;
    else psel_a = 1'b1;
    @(negedge pclk);
    penable = 1'b1;
    pwdata = ~d;
    waits = 0;
    while (!(b ? pready_b : pready_a) && waits < 20) begin
      waits++;
      @(negedge pclk);
    end
    rdat = b ? prdata_b : prdata_a;
    er = b ? pslverr_b : pslverr_a;
    @(negedge pclk);
    psel_a = 1'b0;
    psel_b = 1'b0;
    penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic er;
  int wt;

  initial begin
    presetn = 1'b0;
    psel_a = 1'b0;
    psel_b = 1'b0;
    penable = 1'b0;
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
    repeat (2) @(negedge pclk);
    chk("rst_pready", {31'd0, pready_a}, 32'd0);
    chk("rst_prdata", prdata_a, 32'd0);
    presetn = 1'b1;
    @(negedge pclk);

    xfer(0, 0, 10'h000, 32'h0, rd, er, wt);
    chk("id_rd", rd, 32'hA5B0_0001);
    chk("id_err", {31'd0, er}, 32'd0);
    chk("id_waits", wt, 32'd2);
    chk("post_pready", {31'd0, pready_a}, 32'd0);
    chk("post_prdata", prdata_a, 32'd0);

    xfer(0, 1, 10'h010, 32'hDEAD_BEEF, rd, er, wt);
    chk("wr10_err", {31'd0, er}, 32'd0);
    chk("wr10_waits", wt, 32'd2);
    chk("wr10_prdata", rd, 32'd0);
    xfer(0, 0, 10'h010, 32'h0, rd, er, wt);
    chk("rd10", rd, 32'hDEAD_BEEF);
    chk("rd10_err", {31'd0, er}, 32'd0);
    chk("rd10_waits", wt, 32'd2);

    xfer(0, 1, 10'h002, 32'h1111_1111, rd, er, wt);
    chk("wr_misalign_err", {31'd0, er}, 32'd1);
    xfer(0, 1, 10'h100, 32'h2222_2222, rd, er, wt);
    chk("wr_oor_err", {31'd0, er}, 32'd1);
    xfer(0, 1, 10'h000, 32'h3333_3333, rd, er, wt);
    chk("wr_id_err", {31'd0, er}, 32'd1);
    chk("post_err_pslverr", {31'd0, pslverr_a}, 32'd0);
    xfer(0, 0, 10'h000, 32'h0, rd, er, wt);
    chk("id_rd2", rd, 32'hA5B0_0001);
    chk("id_rd2_err", {31'd0, er}, 32'd0);
    xfer(0, 0, 10'h100, 32'h0, rd, er, wt);
    chk("rd_oor_err", {31'd0, er}, 32'd1);
    chk("rd_oor_data", rd, 32'd0);
    xfer(0, 0, 10'h012, 32'h0, rd, er, wt);
    chk("rd_misalign_err", {31'd0, er}, 32'd1);
    chk("rd_misalign_data", rd, 32'd0);

    // Abort after one wait cycle
    paddr = 10'h020;
    pwrite = 1'b1;
    pwdata = 32'h1234_5678;
    psel_a = 1'b1;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel_a = 1'b0;
    penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("abort_pready", {31'd0, pready_a}, 32'd0);
    end
    xfer(0, 0, 10'h020, 32'h0, rd, er, wt);
    chk("abort_rd", rd, 32'd0);
    chk("abort_waits", wt, 32'd2);

    // Reset while waiting
    paddr = 10'h004;
    pwrite = 1'b1;
    pwdata = 32'h0000_00FF;
    psel_a = 1'b1;
    @(negedge pclk);
    penable = 1'b1;
    #2 presetn = 1'b0;
    #1;
    chk("rst_mid_pready", {31'd0, pready_a}, 32'd0);
    chk("rst_mid_pslverr", {31'd0, pslverr_a}, 32'd0);
    chk("rst_mid_prdata", prdata_a, 32'd0);
    @(negedge pclk);
    psel_a = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    xfer(0, 0, 10'h004, 32'h0, rd, er, wt);
    chk("rst_rd04", rd, 32'd0);
    xfer(0, 0, 10'h010, 32'h0, rd, er, wt);
    chk("rst_rd10", rd, 32'd0);

    // Zero wait states, back-to-back
    xfer(1, 1, 10'h008, 32'd1, rd, er, wt);
    chk("b_wr08_waits", wt, 32'd0);
    chk("b_wr08_err", {31'd0, er}, 32'd0);
    xfer(1, 1, 10'h00C, 32'd2, rd, er, wt);
    chk("b_wr0c_waits", wt, 32'd0);
    xfer(1, 0, 10'h008, 32'h0, rd, er, wt);
    chk("b_rd08", rd, 32'd1);
    chk("b_rd08_waits", wt, 32'd0);
    xfer(1, 0, 10'h00C, 32'h0, rd, er, wt);
    chk("b_rd0c", rd, 32'd2);
    chk("b_rd0c_waits", wt, 32'd0);
    xfer(1, 0, 10'h000, 32'h0, rd, er, wt);
    chk("b_id", rd, 32'hA5B0_0001);
    xfer(1, 1, 10'h000, 32'h5, rd, er, wt);
    chk("b_wr_id_err", {31'd0, er}, 32'd1);
    chk("b_post_pready", {31'd0, pready_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
